// File: rtl/spu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spu_pkg
// Description : Shared opcodes, format codes and pipe-stage record for the
//               SPU odd-pipe branch unit.
// Revision    : 1.0
// ============================================================================
package spu_pkg;

    localparam logic [2:0] FMT_RR   = 3'd0;
    localparam logic [2:0] FMT_RI16 = 3'd5;

    // RI16 opcodes occupy op[2:10]
    localparam logic [8:0] OP_BR    = 9'b001100100;
    localparam logic [8:0] OP_BRA   = 9'b001100000;
    localparam logic [8:0] OP_BRSL  = 9'b001100110;
    localparam logic [8:0] OP_BRASL = 9'b001100010;
    localparam logic [8:0] OP_BRZ   = 9'b001000000;
    localparam logic [8:0] OP_BRNZ  = 9'b001000010;
    localparam logic [8:0] OP_BRHZ  = 9'b001000100;
    localparam logic [8:0] OP_BRHNZ = 9'b001000110;

    localparam logic [10:0] OP_BI    = 11'b00110101000;
    localparam logic [10:0] OP_BISL  = 11'b00110101001;
    localparam logic [10:0] OP_BIZ   = 11'b00100101000;
    localparam logic [10:0] OP_BINZ  = 11'b00100101001;
    localparam logic [10:0] OP_BIHZ  = 11'b00100101010;
    localparam logic [10:0] OP_BIHNZ = 11'b00100101011;

    // pc is held at the widest supported PC_WIDTH and truncated at the output
    typedef struct packed {
        logic         valid;
        logic [0:127] rt;
        logic [0:6]   rt_addr;
        logic         reg_write;
        logic [31:0]  pc;
        logic         taken;
    } br_stage_t;

    localparam br_stage_t BR_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : Combinational decode, condition and target resolution for
//               RR and RI16 branches; non-taken forms collapse to a bubble.
// Revision    : 1.0
// ============================================================================
module branch_resolve
    import spu_pkg::*;
#(
    parameter int PC_WIDTH = 8
) (
    input  logic [0:10]         op,
    input  logic [2:0]          format,
    input  logic [0:6]          rt_addr,
    input  logic [0:127]        ra,
    input  logic [0:127]        rb,
    input  logic [0:127]        rt_val,
    input  logic [0:17]         imm,
    input  logic                reg_write,
    input  logic [PC_WIDTH-1:0] pc_in,
    output br_stage_t           result
);

    logic [31:0]         w_imm_sext;
    logic [31:0]         w_imm_zext;
    logic [31:0]         w_ra_word;
    logic [PC_WIDTH-1:0] w_rel_target;
    logic [PC_WIDTH-1:0] w_abs_target;
    logic [PC_WIDTH-1:0] w_ind_target;
    logic [PC_WIDTH-1:0] w_link_pc;
    logic [PC_WIDTH-1:0] w_target;
    logic                w_word_zero;
    logic                w_half_zero;
    logic                w_take;
    logic                w_link;
    logic                w_unused;

    assign w_imm_sext   = {{16{imm[2]}}, imm[2:17]};
    assign w_imm_zext   = {16'h0000, imm[2:17]};
    assign w_ra_word    = ra[0:31];
    assign w_rel_target = pc_in + w_imm_sext[PC_WIDTH-1:0];
    assign w_abs_target = w_imm_zext[PC_WIDTH-1:0];
    assign w_ind_target = w_ra_word[PC_WIDTH-1:0];
    assign w_link_pc    = pc_in + PC_WIDTH'(1);
    assign w_word_zero  = (rt_val[0:31] == 32'h0);
    assign w_half_zero  = (rt_val[16:31] == 16'h0);

    assign w_unused = ^{rb, ra[32:127], rt_val[32:127], imm[0:1],
                        w_imm_sext, w_imm_zext, w_ra_word};

    always_comb begin
        w_take   = 1'b0;
        w_link   = 1'b0;
        w_target = '0;
        if (format == FMT_RI16) begin
            unique case (op[2:10])
                OP_BR:    begin w_take = 1'b1;         w_target = w_rel_target; end
                OP_BRA:   begin w_take = 1'b1;         w_target = w_abs_target; end
                OP_BRSL:  begin w_take = 1'b1;         w_target = w_rel_target; w_link = 1'b1; end
                OP_BRASL: begin w_take = 1'b1;         w_target = w_abs_target; w_link = 1'b1; end
                OP_BRZ:   begin w_take = w_word_zero;  w_target = w_rel_target; end
                OP_BRNZ:  begin w_take = !w_word_zero; w_target = w_rel_target; end
                OP_BRHZ:  begin w_take = w_half_zero;  w_target = w_rel_target; end
                OP_BRHNZ: begin w_take = !w_half_zero; w_target = w_rel_target; end
                default:  ;
            endcase
        end else if (format == FMT_RR) begin
            unique case (op)
                OP_BI:    begin w_take = 1'b1;         w_target = w_ind_target; end
                OP_BISL:  begin w_take = 1'b1;         w_target = w_ind_target; w_link = 1'b1; end
                OP_BIZ:   begin w_take = w_word_zero;  w_target = w_ind_target; end
                OP_BINZ:  begin w_take = !w_word_zero; w_target = w_ind_target; end
                OP_BIHZ:  begin w_take = w_half_zero;  w_target = w_ind_target; end
                OP_BIHNZ: begin w_take = !w_half_zero; w_target = w_ind_target; end
                default:  ;
            endcase
        end

        result = BR_BUBBLE;
        if (w_take) begin
            result.valid = 1'b1;
            result.taken = 1'b1;
            result.pc    = 32'(w_target);
            if (w_link) begin
                result.rt[0:31]  = 32'(w_link_pc);
                result.rt_addr   = rt_addr;
                result.reg_write = reg_write;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_unit
// Description : SPU odd-pipe branch unit: resolve stage, LATENCY-deep result
//               pipe with flush, and saturating taken-branch counter.
// Revision    : 1.0
// ============================================================================
module branch_unit
    import spu_pkg::*;
#(
    parameter int PC_WIDTH  = 8,
    parameter int LATENCY   = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [0:10]          op,
    input  logic [2:0]           format,
    input  logic [0:6]           rt_addr,
    input  logic [0:127]         ra,
    input  logic [0:127]         rb,
    input  logic [0:127]         rt_val,
    input  logic [0:17]          imm,
    input  logic                 reg_write,
    input  logic [PC_WIDTH-1:0]  pc_in,
    input  logic                 flush,
    output logic [0:127]         rt_wb,
    output logic [0:6]           rt_addr_wb,
    output logic                 reg_write_wb,
    output logic [PC_WIDTH-1:0]  pc_wb,
    output logic                 branch_taken,
    output logic [CNT_WIDTH-1:0] taken_count
);

    br_stage_t            w_resolved;
    br_stage_t            w_load;
    br_stage_t            w_last;
    br_stage_t            r_stage [LATENCY];
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_unused;

    branch_resolve #(
        .PC_WIDTH (PC_WIDTH)
    ) u_resolve (
        .op        (op),
        .format    (format),
        .rt_addr   (rt_addr),
        .ra        (ra),
        .rb        (rb),
        .rt_val    (rt_val),
        .imm       (imm),
        .reg_write (reg_write),
        .pc_in     (pc_in),
        .result    (w_resolved)
    );

    // w_load is what the output stage captures on the next edge; the counter
    // tracks it so the count moves together with the visible branch.
    generate
        if (LATENCY == 1) begin : g_lat_one
            assign w_load = flush ? BR_BUBBLE : w_resolved;
        end else begin : g_lat_multi
            assign w_load = flush ? BR_BUBBLE : r_stage[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= BR_BUBBLE;
            end
        end else begin
            r_stage[0] <= w_resolved;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_load.taken && (r_count != {CNT_WIDTH{1'b1}})) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign w_last       = r_stage[LATENCY-1];
    assign rt_wb        = w_last.rt;
    assign rt_addr_wb   = w_last.rt_addr;
    assign reg_write_wb = w_last.reg_write;
    assign pc_wb        = w_last.pc[PC_WIDTH-1:0];
    assign branch_taken = w_last.valid & w_last.taken;
    assign taken_count  = r_count;

    assign w_unused = ^w_last.pc;

endmodule
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_unit
// Description : Directed self-checking bench for branch_unit at LATENCY 4, 1
//               and 8 (the last with a 2-bit counter), sharing one stimulus.
// Revision    : 1.0
// ============================================================================
module tb_branch_unit;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [0:10]  op = '0;
    logic [2:0]   format = '0;
    logic [0:6]   rt_addr = '0;
    logic [0:127] ra = '0;
    logic [0:127] rb = '0;
    logic [0:127] rt_val = '0;
    logic [0:17]  imm = '0;
    logic         reg_write = 1'b0;
    logic [7:0]   pc_in = '0;
    logic         flush = 1'b0;

    logic [0:127] rt_wb4, rt_wb1, rt_wb8;
    logic [0:6]   rt_addr_wb4, rt_addr_wb1, rt_addr_wb8;
    logic         reg_write_wb4, reg_write_wb1, reg_write_wb8;
    logic [7:0]   pc_wb4, pc_wb1, pc_wb8;
    logic         branch_taken4, branch_taken1, branch_taken8;
    logic [15:0]  taken_count4, taken_count1;
    logic [1:0]   taken_count8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_unit #(.PC_WIDTH(8), .LATENCY(4), .CNT_WIDTH(16)) dut4 (
        .clk(clk), .reset(reset), .op(op), .format(format), .rt_addr(rt_addr),
        .ra(ra), .rb(rb), .rt_val(rt_val), .imm(imm), .reg_write(reg_write),
        .pc_in(pc_in), .flush(flush), .rt_wb(rt_wb4), .rt_addr_wb(rt_addr_wb4),
        .reg_write_wb(reg_write_wb4), .pc_wb(pc_wb4), .branch_taken(branch_taken4),
        .taken_count(taken_count4));

    branch_unit #(.PC_WIDTH(8), .LATENCY(1), .CNT_WIDTH(16)) dut1 (
        .clk(clk), .reset(reset), .op(op), .format(format), .rt_addr(rt_addr),
        .ra(ra), .rb(rb), .rt_val(rt_val), .imm(imm), .reg_write(reg_write),
        .pc_in(pc_in), .flush(flush), .rt_wb(rt_wb1), .rt_addr_wb(rt_addr_wb1),
        .reg_write_wb(reg_write_wb1), .pc_wb(pc_wb1), .branch_taken(branch_taken1),
        .taken_count(taken_count1));

    branch_unit #(.PC_WIDTH(8), .LATENCY(8), .CNT_WIDTH(2)) dut8 (
        .clk(clk), .reset(reset), .op(op), .format(format), .rt_addr(rt_addr),
        .ra(ra), .rb(rb), .rt_val(rt_val), .imm(imm), .reg_write(reg_write),
        .pc_in(pc_in), .flush(flush), .rt_wb(rt_wb8), .rt_addr_wb(rt_addr_wb8),
        .reg_write_wb(reg_write_wb8), .pc_wb(pc_wb8), .branch_taken(branch_taken8),
        .taken_count(taken_count8));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        op = '0; format = '0; rt_addr = '0; ra = '0; rb = '0;
        rt_val = '0; imm = '0; reg_write = 1'b0; pc_in = '0;
    endtask

    // Low 96 bits of rt_val are set so only the tested word can matter.
    task automatic issue_ri16(input logic [8:0] opc, input logic [15:0] im,
                              input logic [7:0] pc, input logic [31:0] rtv,
                              input logic [6:0] rta, input logic rw);
        clear_in();
        op = {2'b00, opc}; format = 3'd5; imm = {2'b00, im}; pc_in = pc;
        rt_val = {rtv, {96{1'b1}}}; rt_addr = rta; reg_write = rw;
    endtask

    task automatic issue_rr(input logic [10:0] opc, input logic [31:0] ra32,
                            input logic [7:0] pc, input logic [31:0] rtv);
        clear_in();
        op = opc; format = 3'd0; ra = {ra32, {96{1'b1}}}; pc_in = pc;
        rt_val = {rtv, {96{1'b1}}}; rt_addr = 7'd7; reg_write = 1'b1;
    endtask

    task automatic test_reset();
        clear_in();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        n_cmp++;
        if ({branch_taken4, pc_wb4, rt_wb4, rt_addr_wb4, reg_write_wb4, taken_count4} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs4: got taken=%b pc=%h cnt=%h required all zero",
                     branch_taken4, pc_wb4, taken_count4);
        end
        n_cmp++;
        if ({taken_count1, taken_count8, branch_taken1, branch_taken8} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_1_8: got cnt1=%h cnt8=%h required 0", taken_count1, taken_count8);
        end
    endtask

    task automatic test_link();
        issue_ri16(9'b001100110, 16'hFFFC, 8'h10, 32'h0, 7'd5, 1'b1);
        step();
        clear_in();
        n_cmp++;
        if ({branch_taken1, pc_wb1, rt_wb1[0:31]} !== {1'b1, 8'h0C, 32'h11}) begin
            n_err++;
            $display("FAIL brsl_lat1: got taken=%b pc=%h link=%h required 1 0c 00000011",
                     branch_taken1, pc_wb1, rt_wb1[0:31]);
        end
        step(); step();
        n_cmp++;
        if (branch_taken4 !== 1'b0) begin
            n_err++;
            $display("FAIL brsl_early: got taken=%b required 0 before latency", branch_taken4);
        end
        step();
        n_cmp++;
        if ({branch_taken4, pc_wb4, rt_addr_wb4, reg_write_wb4} !== {1'b1, 8'h0C, 7'd5, 1'b1}) begin
            n_err++;
            $display("FAIL brsl_out: got taken=%b pc=%h rta=%0d rw=%b required 1 0c 5 1",
                     branch_taken4, pc_wb4, rt_addr_wb4, reg_write_wb4);
        end
        n_cmp++;
        if (rt_wb4 !== {32'h11, 96'h0}) begin
            n_err++;
            $display("FAIL brsl_link: got %h required %h", rt_wb4, {32'h11, 96'h0});
        end
        n_cmp++;
        if (taken_count4 !== 16'd1) begin
            n_err++;
            $display("FAIL brsl_count: got %0d required 1", taken_count4);
        end
    endtask

    task automatic test_brz();
        issue_ri16(9'b001000000, 16'h0003, 8'hFE, 32'h0, 7'd2, 1'b1);
        step();
        issue_ri16(9'b001000000, 16'h0003, 8'hFE, 32'h1, 7'd2, 1'b1);
        step();
        clear_in();
        step(); step();
        n_cmp++;
        if ({branch_taken4, pc_wb4, reg_write_wb4, rt_wb4} !== {1'b1, 8'h01, 1'b0, 128'h0}) begin
            n_err++;
            $display("FAIL brz_taken_wrap: got taken=%b pc=%h rw=%b required 1 01 0",
                     branch_taken4, pc_wb4, reg_write_wb4);
        end
        step();
        n_cmp++;
        if ({branch_taken4, pc_wb4, rt_wb4, rt_addr_wb4, reg_write_wb4, taken_count4}
            !== {1'b0, 8'h00, 128'h0, 7'd0, 1'b0, 16'd2}) begin
            n_err++;
            $display("FAIL brz_bubble: got taken=%b pc=%h cnt=%0d required 0 00 2",
                     branch_taken4, pc_wb4, taken_count4);
        end
    endtask

    task automatic test_bihnz();
        issue_rr(11'b00100101011, 32'h0000_0040, 8'h05, 32'h0000_0001);
        step();
        issue_rr(11'b00100101011, 32'h0000_0040, 8'h05, 32'hFFFF_0000);
        step();
        clear_in();
        step(); step();
        n_cmp++;
        if ({branch_taken4, pc_wb4, reg_write_wb4, rt_wb4} !== {1'b1, 8'h40, 1'b0, 128'h0}) begin
            n_err++;
            $display("FAIL bihnz_taken: got taken=%b pc=%h rw=%b required 1 40 0",
                     branch_taken4, pc_wb4, reg_write_wb4);
        end
        step();
        n_cmp++;
        if ({branch_taken4, pc_wb4, taken_count4} !== {1'b0, 8'h00, 16'd3}) begin
            n_err++;
            $display("FAIL bihnz_bubble: got taken=%b pc=%h cnt=%0d required 0 00 3",
                     branch_taken4, pc_wb4, taken_count4);
        end
    endtask

    task automatic test_back_to_back();
        issue_rr(11'b00110101000, 32'h0000_1234, 8'h00, 32'h0);
        step();
        issue_ri16(9'b001100100, 16'h0005, 8'h20, 32'h0, 7'd1, 1'b1);
        step();
        issue_ri16(9'b001100000, 16'h1280, 8'h20, 32'h0, 7'd1, 1'b1);
        step();
        clear_in();
        step();
        n_cmp++;
        if ({branch_taken4, pc_wb4, reg_write_wb4} !== {1'b1, 8'h34, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_bi: got taken=%b pc=%h rw=%b required 1 34 0",
                     branch_taken4, pc_wb4, reg_write_wb4);
        end
        step();
        n_cmp++;
        if ({branch_taken4, pc_wb4} !== {1'b1, 8'h25}) begin
            n_err++;
            $display("FAIL b2b_br: got taken=%b pc=%h required 1 25", branch_taken4, pc_wb4);
        end
        step();
        n_cmp++;
        if ({branch_taken4, pc_wb4, taken_count4} !== {1'b1, 8'h80, 16'd6}) begin
            n_err++;
            $display("FAIL b2b_bra: got taken=%b pc=%h cnt=%0d required 1 80 6",
                     branch_taken4, pc_wb4, taken_count4);
        end
    endtask

    task automatic test_flush();
        logic seen;
        issue_ri16(9'b001100100, 16'h0001, 8'h00, 32'h0, 7'd1, 1'b0);
        step();
        issue_ri16(9'b001100100, 16'h0001, 8'h08, 32'h0, 7'd1, 1'b0);
        step();
        clear_in();
        flush = 1'b1;
        step();
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | branch_taken4;
        end
        n_cmp++;
        if ({seen, taken_count4} !== {1'b0, 16'd6}) begin
            n_err++;
            $display("FAIL flush_kill: got seen=%b cnt=%0d required 0 6", seen, taken_count4);
        end

        issue_ri16(9'b001100100, 16'h0002, 8'h30, 32'h0, 7'd1, 1'b0);
        step();
        issue_ri16(9'b001100100, 16'h0002, 8'h40, 32'h0, 7'd1, 1'b0);
        step();
        clear_in();
        step(); step();
        flush = 1'b1;
        #1;
        n_cmp++;
        if ({branch_taken4, pc_wb4, taken_count4} !== {1'b1, 8'h32, 16'd7}) begin
            n_err++;
            $display("FAIL flush_exit: got taken=%b pc=%h cnt=%0d required 1 32 7",
                     branch_taken4, pc_wb4, taken_count4);
        end
        step();
        flush = 1'b0;
        seen = branch_taken4;
        for (int i = 0; i < 3; i++) begin
            step();
            seen = seen | branch_taken4;
        end
        n_cmp++;
        if ({seen, taken_count4} !== {1'b0, 16'd7}) begin
            n_err++;
            $display("FAIL flush_younger: got seen=%b cnt=%0d required 0 7", seen, taken_count4);
        end
    endtask

    task automatic test_reset_midstream();
        logic seen;
        for (int k = 0; k < 3; k++) begin
            issue_ri16(9'b001100100, 16'h0001, 8'(8'h60 + k), 32'h0, 7'd1, 1'b0);
            step();
        end
        reset = 1'b1;
        flush = 1'b1;
        step();
        reset = 1'b0;
        flush = 1'b0;
        clear_in();
        n_cmp++;
        if ({branch_taken1, pc_wb1, rt_wb1, rt_addr_wb1, reg_write_wb1, taken_count1} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_lat1: got taken=%b pc=%h cnt=%0d required all zero",
                     branch_taken1, pc_wb1, taken_count1);
        end
        n_cmp++;
        if ({branch_taken4, pc_wb4, taken_count4, branch_taken8, pc_wb8, taken_count8} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_lat4_8: got t4=%b c4=%0d t8=%b c8=%0d required all zero",
                     branch_taken4, taken_count4, branch_taken8, taken_count8);
        end
        seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            seen = seen | branch_taken4 | branch_taken8 | branch_taken1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL reset_inflight: got taken seen=%b required 0", seen);
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 5; k++) begin
            issue_ri16(9'b001100100, 16'h0010, 8'(8'h50 + k), 32'h0, 7'd1, 1'b0);
            step();
        end
        clear_in();
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if ({branch_taken8, pc_wb8, taken_count8} !== {1'b1, 8'h61, 2'd2}) begin
            n_err++;
            $display("FAIL lat8_second: got taken=%b pc=%h cnt=%0d required 1 61 2",
                     branch_taken8, pc_wb8, taken_count8);
        end
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if (taken_count8 !== 2'd3) begin
            n_err++;
            $display("FAIL count_saturate: got %0d required 3", taken_count8);
        end
        n_cmp++;
        if ({taken_count4, taken_count1} !== {16'd5, 16'd5}) begin
            n_err++;
            $display("FAIL count_wide: got c4=%0d c1=%0d required 5 5", taken_count4, taken_count1);
        end
    endtask

    initial begin
        test_reset();
        test_link();
        test_brz();
        test_bihnz();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/branch_unit.md
# branch_unit

Parametrised SPU odd-pipe branch unit. Accepts one decoded instruction per cycle from the RF/FWD stage, resolves all RR and RI16 branch forms (unconditional, absolute, link, word and halfword zero/non-zero, indirect), and delivers the link value, new PC and taken flag to WB after a configurable pipeline depth. Supports in-flight flush and keeps a saturating taken-branch counter.

## Interface
- PC_WIDTH, 8: program-counter width in instruction words.
- LATENCY, 4: cycles from input to WB outputs; legal range 1..8.
- CNT_WIDTH, 16: width of taken-branch counter.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- op  in  [0:10]  decoded opcode; RI16 uses op[2:10].
- format  in  [2:0]  0 = RR, 5 = RI16; other values are non-branch.
- rt_addr  in  [0:6]  destination (link) register.
- ra, rb  in  [0:127]  source values; ra[0:31] is the indirect target.
- rt_val  in  [0:127]  current rt value, tested by conditional forms.
- imm  in  [0:17]  immediate; RI16 uses imm[2:17].
- reg_write  in  1  instruction writes RegTable.
- pc_in  in  [PC_WIDTH-1:0]  PC of the instruction.
- flush  in  1  kill every instruction inside the unit.
- rt_wb  out  [0:127]  link value.
- rt_addr_wb  out  [0:6]  link destination.
- reg_write_wb  out  1  link write enable.
- pc_wb  out  [PC_WIDTH-1:0]  branch target.
- branch_taken  out  1  target valid, redirect fetch.
- taken_count  out  [CNT_WIDTH-1:0]  saturating count of taken branches leaving WB.

## Operation
- RI16 (op[2:10]): br 001100100, bra 001100000, brsl 001100110, brasl 001100010, brz 001000000, brnz 001000010, brhz 001000100, brhnz 001000110.
- RR (op): bi 00110101000, bisl 00110101001, biz 00100101000, binz 00100101001, bihz 00100101010, bihnz 00100101011.
- Relative target = (pc_in + sign-extended imm[2:17]) mod 2^PC_WIDTH. Absolute target = imm[2:17] truncated to PC_WIDTH. Indirect target = ra[32-PC_WIDTH:31].
- Word condition: rt_val[0:31] == 0. Halfword condition: rt_val[16:31] == 0. z forms take on zero, nz forms on non-zero.
- Link forms (brsl, brasl, bisl): rt_wb[0:31] = zero-extended (pc_in + 1) mod 2^PC_WIDTH; rt_wb[32:127] = 0; reg_write_wb = reg_write; always taken.
- All non-link forms: reg_write_wb = 0, rt_wb = 0.
- Not-taken conditional, nop (format 0 with op 0), unknown opcode or other format: bubble. A bubble carries all-zero payload and branch_taken = 0.
- taken_count increments when branch_taken = 1 at the output. It saturates at all-ones and clears only on reset.

## Timing
- Resolution occurs in the first stage. LATENCY-1 further registered stages follow, each holding a valid bit and payload. Outputs come directly from the last stage, so an input sampled on edge N appears after edge N+LATENCY-1.
- Fully pipelined: one instruction per cycle, no stall, no back-pressure.
- flush = 1 on an edge forces every stage, including the one capturing the current input, to a bubble. Outputs are zero from the next cycle.
- flush and a taken branch at the output in the same cycle: the output branch is already visible and counts. Everything younger is killed.
- reset = 1: all stages become bubbles, every output is 0 and taken_count is 0 after the edge. Reset dominates flush and clears instructions already in flight.
- Wrap-around: target and link arithmetic are modulo 2^PC_WIDTH, with no overflow flag.

## Structure
- Shared package spu_pkg: opcode localparams, FMT_RR = 0, FMT_RI16 = 5, and the packed struct br_stage_t (valid, rt, rt_addr, reg_write, pc, taken).
- Sub-module branch_resolve: combinational decode, condition and target logic producing br_stage_t.
- branch_unit: instantiates branch_resolve, a LATENCY-deep br_stage_t shift pipe, flush handling and the counter.

## Test plan
- brsl, pc_in = 8'h10, imm[2:17] = 16'hFFFC, rt_addr = 5, reg_write = 1 -> after LATENCY edges: pc_wb = 8'h0C, branch_taken = 1, rt_wb[0:31] = 32'h11, rt_addr_wb = 5, reg_write_wb = 1, taken_count = 1.
- brz, rt_val[0:31] = 0, imm = 3, pc_in = 8'hFE; then brz with rt_val[0:31] = 1 -> first gives pc_wb = 8'h01 (wrap); second is a bubble and the count is unchanged.
- bihnz, rt_val[16:31] = 16'h0001, rt_val[0:15] = 0, ra[0:31] = 32'h0000_0040 -> pc_wb = 8'h40 and taken; with rt_val[16:31] = 0 the result is a bubble.
- Back-to-back bi, br, bra on consecutive cycles -> three taken outputs on consecutive cycles with the correct order and targets.
- flush asserted one cycle after issuing two branches -> no taken output appears. A branch already at the output when flush rises still exits and counts.
- reset asserted mid-stream with LATENCY = 1 and LATENCY = 8 variants -> all outputs are 0 the next cycle, and taken_count saturates when preloaded with CNT_WIDTH = 2 over five taken branches.
